// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter using reverse double-dabble.
// The digit and binary registers shift right and are corrected once per clock, one bit per cycle.
module bcd2bin_seq #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [BIN_W-1:0]      bin_out
);
    localparam int DW = 4 * DIGITS;
    localparam int CW = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(BIN_W - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t              state_reg, state_next;
    logic [DW-1:0]       digits_reg, digits_next;
    logic [BIN_W-1:0]    bin_reg, bin_next;
    logic [CW-1:0]       cnt_reg, cnt_next;
    logic                busy_reg, busy_next;
    logic                done_reg, done_next;
    logic                err_reg, err_next;
    logic [BIN_W-1:0]    bin_out_reg, bin_out_next;

    logic [DW+BIN_W-1:0] shifted;
    logic [DW-1:0]       fixed_digits;
    logic [DIGITS-1:0]   bad_digit;

    // One right shift of the whole {digits, binary} chain; a zero enters the top digit.
    assign shifted = {digits_reg, bin_reg} >> 1;

    // Correction is a per-digit 4-bit subtract: no borrow crosses a digit boundary.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic [3:0] sd;
            assign sd                    = shifted[BIN_W + gi*4 +: 4];
            assign fixed_digits[gi*4 +: 4] = (sd >= 4'd8) ? (sd - 4'd3) : sd;
            assign bad_digit[gi]         = (bcd_in[gi*4 +: 4] > 4'd9);
        end
    endgenerate

    always_comb begin
        state_next   = state_reg;
        digits_next  = digits_reg;
        bin_next     = bin_reg;
        cnt_next     = cnt_reg;
        busy_next    = 1'b0;
        done_next    = 1'b0;
        err_next     = err_reg;
        bin_out_next = bin_out_reg;
        case (state_reg)
            SHIFT: begin
                digits_next = fixed_digits;
                bin_next    = shifted[BIN_W-1:0];
                cnt_next    = cnt_reg + CW'(1);
                if (cnt_reg == LAST_CNT) begin
                    state_next   = DONE;
                    done_next    = 1'b1;
                    bin_out_next = shifted[BIN_W-1:0];
                end else begin
                    busy_next = 1'b1;
                end
            end
            default: begin
                // IDLE and DONE both accept a new request.
                if (start) begin
                    digits_next = bcd_in;
                    bin_next    = '0;
                    cnt_next    = '0;
                    if (|bad_digit) begin
                        state_next   = DONE;
                        done_next    = 1'b1;
                        err_next     = 1'b1;
                        bin_out_next = '0;
                    end else begin
                        state_next = SHIFT;
                        busy_next  = 1'b1;
                        err_next   = 1'b0;
                    end
                end else begin
                    state_next = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            digits_reg  <= '0;
            bin_reg     <= '0;
            cnt_reg     <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            err_reg     <= 1'b0;
            bin_out_reg <= '0;
        end else begin
            state_reg   <= state_next;
            digits_reg  <= digits_next;
            bin_reg     <= bin_next;
            cnt_reg     <= cnt_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
            err_reg     <= err_next;
            bin_out_reg <= bin_out_next;
        end
    end

    assign busy    = busy_reg;
    assign done    = done_reg;
    assign err     = err_reg;
    assign bin_out = bin_out_reg;
endmodule

// File: tb/tb_bcd2bin_seq.sv
// Randomized self-checking bench for bcd2bin_seq against a decimal-arithmetic reference.
module tb_bcd2bin_seq;
    localparam int DIGITS = 3;
    localparam int BIN_W  = 10;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [11:0]       bcd_in;
    logic              busy, done, err;
    logic [BIN_W-1:0]  bin_out;

    int n_checks = 0;
    int n_errors = 0;

    bcd2bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bcd_in(bcd_in),
        .busy(busy), .done(done), .err(err), .bin_out(bin_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Reference: operand is valid when every nibble is a decimal digit; value is plain decimal.
    function automatic bit ref_valid(input logic [11:0] b);
        return (b[3:0] <= 9) && (b[7:4] <= 9) && (b[11:8] <= 9);
    endfunction

    function automatic int ref_value(input logic [11:0] b);
        if (!ref_valid(b)) return 0;
        return int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [11:0] to_bcd(input int v);
        logic [11:0] r;
        r[11:8] = 4'(v / 100);
        r[7:4]  = 4'((v / 10) % 10);
        r[3:0]  = 4'(v % 10);
        return r;
    endfunction

    // Called right after the accepting edge; ends on the negedge where done is seen.
    task automatic wait_result(input logic [11:0] b, input int inject_at);
        int  n = -1;
        int  busy_cnt = 0;
        bit  ok = ref_valid(b);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == inject_at) begin
                start  = 1'b1;
                bcd_in = 12'h777;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                n = i;
                break;
            end
            if (busy) busy_cnt++;
        end
        start = 1'b0;
        if (n < 0) begin
            check("done_timeout", 32'(n), 32'(ok ? BIN_W : 0));
        end else begin
            check("latency", 32'(n), 32'(ok ? BIN_W : 0));
            check("busy_cycles", 32'(busy_cnt), 32'(ok ? BIN_W : 0));
            check("busy_at_done", 32'(busy), 32'(0));
            check("bin_out", 32'(bin_out), 32'(ref_value(b)));
            check("err", 32'(err), 32'(!ok));
        end
        $display("conv bcd=%03h exp=%0d got=%0d err=%0d lat=%0d", b, ref_value(b), bin_out, err, n);
    endtask

    // Must be entered on a negedge.
    task automatic launch(input logic [11:0] b, input int inject_at);
        start  = 1'b1;
        bcd_in = b;
        @(posedge clk);
        #1;
        start  = 1'b0;
        bcd_in = 12'($urandom);
        wait_result(b, inject_at);
    endtask

    task automatic count_done(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done) cnt++;
        end
    endtask

    int order[1000];
    int cnt;

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        bcd_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_bin_out", 32'(bin_out), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Full-scale operand, then done must fall after one cycle.
        launch(12'h999, -1);
        @(negedge clk);
        check("done_one_cycle", 32'(done), 0);

        // Back-to-back with start held on the DONE cycle.
        launch(12'h000, -1);
        launch(12'h512, -1);

        // Invalid then valid.
        launch(12'h9A3, -1);
        launch(12'h042, -1);

        // Start pulse mid-conversion is ignored; exactly one done.
        @(negedge clk);
        launch(12'h123, 4);
        count_done(15, cnt);
        check("extra_done", 32'(cnt), 0);

        // Reset mid-SHIFT.
        start  = 1'b1;
        bcd_in = 12'h888;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        check("abort_err", 32'(err), 0);
        check("abort_bin_out", 32'(bin_out), 0);
        @(negedge clk);
        rst_n = 1'b1;
        count_done(15, cnt);
        check("done_after_abort", 32'(cnt), 0);
        launch(12'h888, -1);

        // Exhaustive sweep in shuffled order with random idle gaps.
        for (int i = 0; i < 1000; i++) order[i] = i;
        for (int i = 999; i > 0; i--) begin
            int j = int'($urandom_range(0, i));
            int t = order[i];
            order[i] = order[j];
            order[j] = t;
        end
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
            launch(to_bcd(order[i]), -1);
        end

        // Random raw words, mostly containing non-decimal nibbles.
        for (int i = 0; i < 40; i++) launch(12'($urandom), -1);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
